// File: rtl/seven_seg_scan.sv
// Time-multiplexed 8-digit hex display driver for two captured 16-bit values.
// Active-low segments and anodes, registered, with optional per-group leading-zero blanking.
module seven_seg_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 17
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Valid,
    input  logic [15:0] V0,
    input  logic [15:0] V1,
    input  logic        BlankLZ,
    output logic [6:0]  Out7,
    output logic [7:0]  EnOut,
    output logic [2:0]  DigitIdx
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       digit_idx_q, digit_idx_d;
    logic [31:0]      disp_q, disp_d;
    logic [6:0]       out7_q, out7_d;
    logic [7:0]       en_q, en_d;
    logic [3:0]       nibble_s;
    logic [15:0]      group_s;
    logic             blank_s;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    // A digit is a leading zero when it and every higher nibble of its group are zero;
    // position 0 of a group always shows, so a zero value still reads "0".
    function automatic logic leading_zero(input logic [15:0] grp, input logic [1:0] pos);
        logic lz;
        case (pos)
            2'd0:    lz = 1'b0;
            2'd1:    lz = (grp[15:4] == 12'h000);
            2'd2:    lz = (grp[15:8] == 8'h00);
            2'd3:    lz = (grp[15:12] == 4'h0);
            default: lz = 1'b0;
        endcase
        return lz;
    endfunction

    // Next-state for prescaler, scan index, capture register and output stage.
    always_comb begin
        cnt_d       = cnt_q;
        digit_idx_d = digit_idx_q;
        disp_d      = disp_q;
        out7_d      = 7'h7F;
        en_d        = 8'hFF;

        if (cnt_q >= CNT_LAST) begin
            cnt_d       = {CNT_W{1'b0}};
            digit_idx_d = digit_idx_q + 3'd1;
        end else begin
            cnt_d       = cnt_q + CNT_W'(1);
            digit_idx_d = digit_idx_q;
        end

        if (Valid) begin
            disp_d = {V0, V1};
        end else begin
            disp_d = disp_q;
        end

        nibble_s = disp_q[{digit_idx_q, 2'b00} +: 4];
        group_s  = digit_idx_q[2] ? disp_q[31:16] : disp_q[15:0];
        blank_s  = BlankLZ & leading_zero(group_s, digit_idx_q[1:0]);

        if (blank_s) begin
            out7_d = 7'h7F;
            en_d   = 8'hFF;
        end else begin
            out7_d = hex_to_seg(nibble_s);
            en_d   = ~(8'h01 << digit_idx_q);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q       <= {CNT_W{1'b0}};
            digit_idx_q <= 3'd0;
            disp_q      <= 32'h0000_0000;
            out7_q      <= 7'h7F;
            en_q        <= 8'hFF;
        end else begin
            cnt_q       <= cnt_d;
            digit_idx_q <= digit_idx_d;
            disp_q      <= disp_d;
            out7_q      <= out7_d;
            en_q        <= en_d;
        end
    end

    assign Out7     = out7_q;
    assign EnOut    = en_q;
    assign DigitIdx = digit_idx_q;

endmodule
